// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller: instruction
// field encodings, ALU mnemonics, FSM states and the decoded control word.
package multicycle_ctrl_pkg;

  // Opcode field, instr[8:6]
  localparam logic [2:0] opLW    = 3'b000;
  localparam logic [2:0] opSW    = 3'b001;
  localparam logic [2:0] opADD   = 3'b010;
  localparam logic [2:0] opSUB   = 3'b011;
  localparam logic [2:0] opCEQ   = 3'b100;
  localparam logic [2:0] opCLT   = 3'b101;
  localparam logic [2:0] opSEI   = 3'b110;
  localparam logic [2:0] opOTHER = 3'b111;

  // Function field, instr[2:0], meaningful only for opOTHER.
  // fnB0/fnB1 differ only in bit 0, which is the flag value that takes the branch.
  localparam logic [2:0] fnSHIFTL_X = 3'b000;
  localparam logic [2:0] fnSHIFTL_F = 3'b001;
  localparam logic [2:0] fnSHIFTL_O = 3'b010;
  localparam logic [2:0] fnSHIFTR_X = 3'b011;
  localparam logic [2:0] fnSHIFTR_F = 3'b100;
  localparam logic [2:0] fnSHIFTR_O = 3'b101;
  localparam logic [2:0] fnB0       = 3'b110;
  localparam logic [2:0] fnB1       = 3'b111;

  // ALU operation mnemonics (op_mne)
  localparam logic [2:0] mneADD = 3'd0;
  localparam logic [2:0] mneSUB = 3'd1;
  localparam logic [2:0] mneCLR = 3'd2;
  localparam logic [2:0] mneLSH = 3'd3;
  localparam logic [2:0] mneRSH = 3'd4;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_FLAG = 2'd1,
    FILL_ONES = 2'd2
  } shift_fill_t;

  typedef struct packed {
    logic [2:0]  alu_op;
    shift_fill_t shift_fill;
    logic        imm_sel;
    logic        reg_we;
    logic        mem_to_reg;
    logic        flag_we;
    logic        is_mem;
    logic        is_store;
    logic        is_branch;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational instruction decoder: 9-bit instruction word in,
// control word out. The register fields in instr[5:3] belong to the datapath.
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [8:0] instr,
  output ctrl_word_t ctrl
);

  logic [2:0] opcode;
  logic [2:0] funct;
  logic       unusedRegField;

  assign opcode         = instr[8:6];
  assign funct          = instr[2:0];
  assign unusedRegField = ^instr[5:3];

  // Map opcode/function to ALU operation, operand select and write-back controls
  always_comb begin
    ctrl = '0;
    ctrl.shift_fill = FILL_ZERO;
    case (opcode)
      opLW: begin
        ctrl.alu_op     = mneADD;
        ctrl.imm_sel    = 1'b1;
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.is_mem     = 1'b1;
      end
      opSW: begin
        ctrl.alu_op   = mneADD;
        ctrl.imm_sel  = 1'b1;
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      opADD: begin
        ctrl.alu_op = mneADD;
        ctrl.reg_we = 1'b1;
      end
      opSUB: begin
        ctrl.alu_op = mneSUB;
        ctrl.reg_we = 1'b1;
      end
      opCEQ, opCLT: begin
        ctrl.alu_op  = mneSUB;
        ctrl.flag_we = 1'b1;
      end
      opSEI: begin
        ctrl.alu_op  = mneCLR;
        ctrl.imm_sel = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      default: begin
        case (funct)
          fnSHIFTL_X: begin ctrl.alu_op = mneLSH; ctrl.shift_fill = FILL_ZERO; ctrl.reg_we = 1'b1; end
          fnSHIFTL_F: begin ctrl.alu_op = mneLSH; ctrl.shift_fill = FILL_FLAG; ctrl.reg_we = 1'b1; end
          fnSHIFTL_O: begin ctrl.alu_op = mneLSH; ctrl.shift_fill = FILL_ONES; ctrl.reg_we = 1'b1; end
          fnSHIFTR_X: begin ctrl.alu_op = mneRSH; ctrl.shift_fill = FILL_ZERO; ctrl.reg_we = 1'b1; end
          fnSHIFTR_F: begin ctrl.alu_op = mneRSH; ctrl.shift_fill = FILL_FLAG; ctrl.reg_we = 1'b1; end
          fnSHIFTR_O: begin ctrl.alu_op = mneRSH; ctrl.shift_fill = FILL_ONES; ctrl.reg_we = 1'b1; end
          default:    ctrl.is_branch = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetches over a req/ack handshake, decodes, and
// sequences ALU, memory and write-back control with timeout and retire count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [8:0]       instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             cond_flag,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic [2:0]       alu_op,
  output logic [1:0]       shift_fill,
  output logic             imm_sel,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             flag_we,
  output logic             pc_en,
  output logic             pc_branch,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int            TW           = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_t   state;
  ctrl_state_t   nextState;
  ctrl_state_t   fetchOrHalt;
  logic [8:0]    irReg;
  ctrl_word_t    decWord;
  ctrl_word_t    ctrlReg;
  logic [TW-1:0] timeoutCnt;
  logic          timeoutHit;
  logic          branchTaken;

  ctrl_decode uDecode (
    .instr (irReg),
    .ctrl  (decWord)
  );

  // halt_req only matters at the moment the FSM would enter FETCH, so it is
  // folded into every transition toward FETCH and imem_req never rises.
  assign fetchOrHalt = halt_req ? HALT : FETCH;
  assign timeoutHit  = (timeoutCnt == TIMEOUT_LAST);
  assign branchTaken = (cond_flag == irReg[0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    nextState  = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_load    = 1'b0;
    alu_op     = 3'd0;
    shift_fill = 2'd0;
    imm_sel    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    flag_we    = 1'b0;
    pc_en      = 1'b0;
    pc_branch  = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = fetchOrHalt;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load   = 1'b1;
          nextState = DECODE;
        end else if (timeoutHit) begin
          nextState = ERR;
        end
      end
      DECODE: nextState = EXEC;
      EXEC: begin
        alu_op     = ctrlReg.alu_op;
        shift_fill = ctrlReg.shift_fill;
        imm_sel    = ctrlReg.imm_sel;
        if (ctrlReg.is_branch) begin
          pc_en     = 1'b1;
          pc_branch = branchTaken;
          nextState = fetchOrHalt;
        end else if (ctrlReg.is_mem) begin
          nextState = MEM;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrlReg.is_store;
        alu_op   = ctrlReg.alu_op;
        if (dmem_ack) begin
          if (ctrlReg.is_store) begin
            pc_en     = 1'b1;
            nextState = fetchOrHalt;
          end else begin
            nextState = WB;
          end
        end else if (timeoutHit) begin
          nextState = ERR;
        end
      end
      WB: begin
        pc_en      = 1'b1;
        reg_we     = ctrlReg.reg_we;
        mem_to_reg = ctrlReg.mem_to_reg;
        flag_we    = ctrlReg.flag_we;
        nextState  = fetchOrHalt;
      end
      HALT:    nextState = HALT;
      ERR:     nextState = ERR;
      default: nextState = ERR;
    endcase
  end

  assign busy = (state != IDLE) && (state != HALT) && (state != ERR);
  assign done = (state == HALT);
  assign err  = (state == ERR);

  // Capture the instruction on fetch ack and latch its control word in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irReg   <= '0;
      ctrlReg <= '0;
    end else begin
      if (state == FETCH && imem_ack) irReg <= instr;
      if (state == DECODE) ctrlReg <= decWord;
    end
  end

  // Request timeout counter: restarts on every state change, counts unacked cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt <= '0;
    end else if (nextState != state || state == IDLE) begin
      timeoutCnt <= '0;
    end else if ((state == FETCH && !imem_ack) || (state == MEM && !dmem_ack)) begin
      timeoutCnt <= timeoutCnt + TW'(1);
    end
  end

  // Saturating retired-instruction counter, cleared while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (state == IDLE) begin
      retired <= '0;
    end else if (pc_en && retired != {CNT_W{1'b1}}) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: one task per scenario, each with
// hand-computed expectations.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [8:0]  instr = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        cond_flag = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_load;
  logic [2:0]  alu_op;
  logic [1:0]  shift_fill;
  logic        imm_sel, reg_we, mem_to_reg, flag_we, pc_en, pc_branch;
  logic        busy, done, err;
  logic [15:0] retired;
  logic [18:0] allOuts;

  int errors = 0;
  int checks = 0;

  localparam logic [8:0] wADD  = 9'b010_001_010;
  localparam logic [8:0] wLW   = 9'b000_011_001;
  localparam logic [8:0] wSW   = 9'b001_010_011;
  localparam logic [8:0] wB0   = 9'b111_000_110;
  localparam logic [8:0] wB1   = 9'b111_000_111;

  multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .instr(instr),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .cond_flag(cond_flag),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
    .alu_op(alu_op), .shift_fill(shift_fill), .imm_sel(imm_sel), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .flag_we(flag_we), .pc_en(pc_en), .pc_branch(pc_branch),
    .busy(busy), .done(done), .err(err), .retired(retired)
  );

  assign allOuts = {imem_req, dmem_req, dmem_we, ir_load, alu_op, shift_fill, imm_sel,
                    reg_we, mem_to_reg, flag_we, pc_en, pc_branch, busy, done, err};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // From FETCH: present a word with an immediate ack; ends in DECODE
  task automatic fetchWord(input logic [8:0] w);
    instr = w; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (allOuts !== '0) begin errors++; $display("[TB] FAIL reset_outputs: got %b want 0", allOuts); end
    checks++; if (retired !== 16'd0) begin errors++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
    #3; rst_n = 1'b1;
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold_busy: got %0b want 0", busy); end
  endtask

  task automatic test_add();
    instr = wADD; start = 1'b1;
    tick();
    start = 1'b0; imem_ack = 1'b1;
    #1;
    checks++; if ({imem_req, ir_load, busy} !== 3'b111) begin errors++; $display("[TB] FAIL add_fetch: got %b want 111", {imem_req, ir_load, busy}); end
    tick();
    imem_ack = 1'b0;
    #1;
    checks++; if ({imem_req, dmem_req, ir_load, reg_we, pc_en, flag_we} !== 6'b0) begin errors++; $display("[TB] FAIL add_decode_quiet: got %b want 000000", {imem_req, dmem_req, ir_load, reg_we, pc_en, flag_we}); end
    tick(); #1;
    checks++; if ({alu_op, imm_sel, pc_en, reg_we} !== {3'd0, 3'b000}) begin errors++; $display("[TB] FAIL add_exec: got %b want 000000", {alu_op, imm_sel, pc_en, reg_we}); end
    tick(); #1;
    checks++; if ({reg_we, pc_en, mem_to_reg, flag_we} !== 4'b1100) begin errors++; $display("[TB] FAIL add_wb: got %b want 1100", {reg_we, pc_en, mem_to_reg, flag_we}); end
    tick(); #1;
    checks++; if (retired !== 16'd1) begin errors++; $display("[TB] FAIL add_retired: got %0d want 1", retired); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL add_next_fetch: got %0b want 1", imem_req); end
  endtask

  task automatic test_lw();
    int reqCycles = 0;
    fetchWord(wLW);
    tick(); #1;
    checks++; if ({alu_op, imm_sel} !== {3'd0, 1'b1}) begin errors++; $display("[TB] FAIL lw_exec: got %b want 0001", {alu_op, imm_sel}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (dmem_req === 1'b1 && dmem_we === 1'b0 && alu_op === 3'd0) reqCycles++;
      if (i == 3) begin
        checks++; if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL lw_mem_pc_en: got %0b want 0", pc_en); end
      end
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    checks++; if (reqCycles != 4) begin errors++; $display("[TB] FAIL lw_req_cycles: got %0d want 4", reqCycles); end
    checks++; if ({dmem_req, reg_we, mem_to_reg, pc_en} !== 4'b0111) begin errors++; $display("[TB] FAIL lw_wb: got %b want 0111", {dmem_req, reg_we, mem_to_reg, pc_en}); end
    tick(); #1;
    checks++; if (retired !== 16'd2) begin errors++; $display("[TB] FAIL lw_retired: got %0d want 2", retired); end
  endtask

  task automatic test_branch();
    logic [8:0] words [3] = '{wB1, wB1, wB0};
    logic       flags [3] = '{1'b1, 1'b0, 1'b0};
    logic       taken [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      cond_flag = flags[k];
      fetchWord(words[k]);
      tick(); #1;
      checks++; if ({pc_en, pc_branch, reg_we, flag_we} !== {1'b1, taken[k], 2'b00}) begin errors++; $display("[TB] FAIL branch%0d_exec: got %b want %b", k, {pc_en, pc_branch, reg_we, flag_we}, {1'b1, taken[k], 2'b00}); end
      tick(); #1;
      checks++; if (imem_req !== 1'b1 || retired !== 16'(3 + k)) begin errors++; $display("[TB] FAIL branch%0d_refetch: req=%0b retired=%0d want req=1 retired=%0d", k, imem_req, retired, 3 + k); end
    end
    cond_flag = 1'b0;
  endtask

  task automatic test_alu_ops();
    // word, {alu_op, shift_fill, imm_sel}, {reg_we, flag_we}
    logic [8:0] words [6] = '{9'b100_000_000, 9'b111_000_101, 9'b110_000_000,
                              9'b011_000_000, 9'b111_000_001, 9'b101_000_000};
    logic [5:0] expEx [6] = '{6'b001_00_0, 6'b100_10_0, 6'b010_00_1,
                              6'b001_00_0, 6'b011_01_0, 6'b001_00_0};
    logic [1:0] expWb [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int k = 0; k < 6; k++) begin
      fetchWord(words[k]);
      tick(); #1;
      checks++; if ({alu_op, shift_fill, imm_sel} !== expEx[k]) begin errors++; $display("[TB] FAIL aluop%0d_exec: got %b want %b", k, {alu_op, shift_fill, imm_sel}, expEx[k]); end
      tick(); #1;
      checks++; if ({reg_we, flag_we, mem_to_reg, pc_en} !== {expWb[k], 2'b01}) begin errors++; $display("[TB] FAIL aluop%0d_wb: got %b want %b", k, {reg_we, flag_we, mem_to_reg, pc_en}, {expWb[k], 2'b01}); end
      tick();
    end
    #1;
    checks++; if (retired !== 16'd11) begin errors++; $display("[TB] FAIL aluops_retired: got %0d want 11", retired); end
  endtask

  task automatic test_sw();
    fetchWord(wSW);
    start = 1'b1; halt_req = 1'b1; dmem_ack = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++; if ({alu_op, imm_sel, dmem_req} !== {3'd0, 2'b10}) begin errors++; $display("[TB] FAIL sw_exec: got %b want 00010", {alu_op, imm_sel, dmem_req}); end
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++; if ({dmem_req, dmem_we, pc_en, reg_we} !== 4'b1110) begin errors++; $display("[TB] FAIL sw_mem: got %b want 1110", {dmem_req, dmem_we, pc_en, reg_we}); end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || retired !== 16'd12) begin errors++; $display("[TB] FAIL sw_refetch: req=%0b retired=%0d want req=1 retired=12", imem_req, retired); end
  endtask

  task automatic test_reset_mid();
    fetchWord(wLW);
    tick(); tick();
    #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_mem: got %0b want 1", dmem_req); end
    #2; rst_n = 1'b0;
    #1;
    checks++; if (allOuts !== '0 || retired !== 16'd0) begin errors++; $display("[TB] FAIL midrst_outputs: got %b retired=%0d want 0", allOuts, retired); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt();
    resetDut();
    instr = wADD; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      halt_req = (k == 0);
      tick();
      halt_req = 1'b0;
      tick();
      halt_req = (k == 1);
      tick();
      halt_req = 1'b0;
    end
    #1;
    checks++; if ({done, busy, imem_req} !== 3'b100 || retired !== 16'd2) begin errors++; $display("[TB] FAIL halt_state: dbr=%b retired=%0d want 100 retired=2", {done, busy, imem_req}, retired); end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++; if ({done, imem_req} !== 2'b10) begin errors++; $display("[TB] FAIL halt_absorb: got %b want 10", {done, imem_req}); end
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    resetDut();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (imem_req === 1'b1) reqCycles++;
      tick();
    end
    #1;
    checks++; if (reqCycles != 8) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d want 8", reqCycles); end
    checks++; if ({err, imem_req, busy} !== 3'b100) begin errors++; $display("[TB] FAIL timeout_err: got %b want 100", {err, imem_req, busy}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_absorb: got %0b want 1", err); end
    rst_n = 1'b0;
    #1;
    checks++; if ({err, busy} !== 2'b00) begin errors++; $display("[TB] FAIL err_reset: got %b want 00", {err, busy}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ack_wins();
    resetDut();
    instr = wADD; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imem_ack = (i == 7);
      #1;
      tick();
    end
    imem_ack = 1'b0;
    #1;
    checks++; if ({err, busy, imem_req} !== 3'b010) begin errors++; $display("[TB] FAIL ack_wins: got %b want 010", {err, busy, imem_req}); end
  endtask

  initial begin
    $display("[TB] multicycle_ctrl directed test start");
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_alu_ops();
    test_sw();
    test_reset_mid();
    test_halt();
    test_timeout();
    test_ack_wins();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the 9-bit-instruction processor. It fetches each instruction through a request/acknowledge handshake and decodes the 3-bit opcode and 3-bit function fields using the shared opcode/function constants. It then drives the ALU, register file, flag register, data memory and PC control for a variable number of cycles per instruction. It sits between the instruction/data memories and the datapath, which is a separate block.

Parameters:
MEM_TIMEOUT, 8, maximum cycles to wait for imem_ack/dmem_ack before entering ERR
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE and begins fetching
halt_req  in  1  sampled in FETCH entry; stops execution cleanly
instr  in  9  instruction word; valid in the cycle imem_ack=1
imem_ack  in  1  instruction memory acknowledge
dmem_ack  in  1  data memory acknowledge
cond_flag  in  1  current flag register value, used by branches
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable; valid with dmem_req
ir_load  out  1  latch instr into the datapath IR
alu_op  out  3  op_mne encoding
shift_fill  out  2  0 = zero fill, 1 = flag fill, 2 = ones fill
imm_sel  out  1  ALU B operand is the immediate
reg_we  out  1  register file write
mem_to_reg  out  1  write-back source is data memory
flag_we  out  1  flag register write
pc_en  out  1  PC update strobe, one pulse per retired instruction
pc_branch  out  1  with pc_en: load branch target instead of PC+1
busy  out  1  state is not IDLE, HALT or ERR
done  out  1  state is HALT
err  out  1  state is ERR
retired  out  CNT_W  count of retired instructions, saturating

Behaviour:
- Reset (asynchronous) forces state IDLE. All outputs are 0, retired=0 and the IR copy is 0.
- State encoding (shared enum): IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- IDLE: start=1 -> FETCH. Clears retired and the timeout counter.
- FETCH:
  - On entry, halt_req=1 -> HALT, and imem_req is never raised.
  - Otherwise imem_req=1 until imem_ack.
  - imem_ack=1 -> ir_load=1 the same cycle, internal IR captured, next state DECODE.
- DECODE: one cycle, no side effects. Latches the decoded control word.
- EXEC: alu_op and imm_sel are driven per opcode.
  - opLW, opSW: ADD, imm_sel=1; next MEM.
  - opADD: ADD; next WB.
  - opSUB: SUB; next WB.
  - opCEQ, opCLT: SUB; next WB.
  - opSEI: CLR, imm_sel=1; next WB.
  - opOTHER, fnSHIFTL_X/F/O: LSH, shift_fill=0/1/2; next WB.
  - opOTHER, fnSHIFTR_X/F/O: RSH, shift_fill=0/1/2; next WB.
  - opOTHER, fnB0/fnB1: branch is taken when cond_flag==0 (B0) or cond_flag==1 (B1). pc_en=1 and pc_branch=taken in this cycle; next FETCH. No register or flag write.
- MEM: dmem_req=1, with dmem_we=1 for SW and 0 for LW.
  - On dmem_ack: SW asserts pc_en and returns to FETCH; LW goes to WB.
  - alu_op is held stable throughout MEM.
- WB: one cycle, then FETCH. pc_en=1 for every instruction that reaches WB.
  - CEQ, CLT: flag_we=1, reg_we=0.
  - LW: reg_we=1, mem_to_reg=1.
  - ADD, SUB, SEI, shifts: reg_we=1, mem_to_reg=0.
- Cycle counts with acks arriving in the first request cycle:
  - branch: 3
  - ALU, shift, SEI, CEQ, CLT: 4
  - SW: 4
  - LW: 5
- Timeout:
  - The counter resets on entry to FETCH or MEM and increments every cycle a request is outstanding without ack.
  - Reaching MEM_TIMEOUT with no ack -> ERR. All requests drop the next cycle.
  - An ack in the same cycle the counter reaches MEM_TIMEOUT wins over the timeout.
- retired increments in every cycle pc_en=1 and saturates at all-ones.
- HALT and ERR are absorbing. Only rst_n leaves them; start is ignored there.
- Other boundary rules:
  - start while busy is ignored.
  - Acks arriving while no request is outstanding are ignored.
  - halt_req is ignored outside FETCH entry.
- Reset asserted mid-instruction aborts immediately. No pc_en, reg_we or dmem_req glitch is permitted after rst_n falls.
- All outputs are registered, or decoded from registered state plus registered control only. alu_op and shift_fill must not combinationally depend on ack inputs.

Decomposition:
- Shared package holds: the state enum (ctrl_state_t), a shift_fill encoding enum, and a control-word struct {alu_op, shift_fill, imm_sel, reg_we, mem_to_reg, flag_we, is_mem, is_store, is_branch}.
- Sub-module: ctrl_decode. Combinational 9-bit instruction -> control word, unit-testable alone.
- The FSM, timeout counter and retired counter stay in multicycle_ctrl.

Test Plan:
- Reset then start; opADD word 010_001_010 with immediate acks -> imem_req for 1 cycle, then DECODE, then EXEC with alu_op=ADD, then WB with reg_we=1 and pc_en=1. 4 cycles total, retired=1.
- opLW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with mem_to_reg=1. retired increments once.
- fnB1 with cond_flag=1 -> EXEC cycle has pc_en=1, pc_branch=1. Same instruction with cond_flag=0 -> pc_en=1, pc_branch=0. Never reg_we.
- opCEQ -> flag_we=1 in WB and reg_we=0. fnSHIFTR_O -> alu_op=RSH, shift_fill=2.
- imem_ack withheld, MEM_TIMEOUT=8 -> ERR after 8 request cycles, err=1, imem_req=0; start ignored; rst_n low returns to IDLE.
- halt_req high when entering FETCH after 2 instructions -> done=1, retired=2, no imem_req. rst_n pulsed during MEM -> all outputs 0 asynchronously.
